// File: rtl/eth_ping_rx_pkg.sv
// Shared definitions for the ping-frame receiver: parser states, header offsets
// and the default EtherType.
package eth_ping_rx_pkg;

  localparam int unsigned OFF_W = 5;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HDR  = 2'd2,
    ST_TAIL = 2'd3
  } state_e;

  localparam logic [OFF_W-1:0] OFF_ETYPE = 5'd12;
  localparam logic [OFF_W-1:0] OFF_ID    = 5'd14;
  localparam logic [OFF_W-1:0] OFF_SEQ   = 5'd18;
  localparam logic [OFF_W-1:0] OFF_TX    = 5'd22;
  localparam logic [OFF_W-1:0] OFF_END   = 5'd29;

  localparam logic [15:0] DEFAULT_ETYPE = 16'h88B5;

endpackage

// File: rtl/eth_ping_rx_hdr_cmp.sv
// Expected header byte for a given frame offset; care_c_o is low for bytes
// that are not checked (source MAC and everything from the sequence number on).
module eth_ping_rx_hdr_cmp
  import eth_ping_rx_pkg::*;
#(
  parameter logic [47:0] main_mac   = 48'h7A_65_64_6E_74_6D,
  parameter logic [31:0] identifier = 32'h50696E47,
  parameter logic [15:0] ethertype  = DEFAULT_ETYPE
) (
  input  logic [OFF_W-1:0] offset_i,
  output logic [7:0]       exp_byte_c_o,
  output logic             care_c_o
);

  always_comb begin
    exp_byte_c_o = 8'h00;
    care_c_o     = 1'b1;
    case (offset_i)
      5'd0:              exp_byte_c_o = main_mac[47:40];
      5'd1:              exp_byte_c_o = main_mac[39:32];
      5'd2:              exp_byte_c_o = main_mac[31:24];
      5'd3:              exp_byte_c_o = main_mac[23:16];
      5'd4:              exp_byte_c_o = main_mac[15:8];
      5'd5:              exp_byte_c_o = main_mac[7:0];
      OFF_ETYPE:         exp_byte_c_o = ethertype[15:8];
      OFF_ETYPE + 5'd1:  exp_byte_c_o = ethertype[7:0];
      OFF_ID:            exp_byte_c_o = identifier[31:24];
      OFF_ID + 5'd1:     exp_byte_c_o = identifier[23:16];
      OFF_ID + 5'd2:     exp_byte_c_o = identifier[15:8];
      OFF_ID + 5'd3:     exp_byte_c_o = identifier[7:0];
      default:           care_c_o     = 1'b0;
    endcase
  end

endmodule

// File: rtl/eth_ping_rx.sv
// Receive-side ping frame parser: matches the header of each TEMAC RX frame,
// extracts seq/tx_time, timestamps arrival and presents one result at a time.
module eth_ping_rx
  import eth_ping_rx_pkg::*;
#(
  parameter logic [47:0] main_mac   = 48'h7A_65_64_6E_74_6D,
  parameter logic [31:0] identifier = 32'h50696E47,
  parameter logic [15:0] ethertype  = DEFAULT_ETYPE
) (
  input  logic        s_axis_clk,
  input  logic        s_axis_resetn,
  input  logic        enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  input  logic [63:0] current_time,
  input  logic        time_running,
  output logic        m_res_valid,
  input  logic        m_res_ready,
  output logic [31:0] m_res_seq,
  output logic [63:0] m_res_tx_time,
  output logic [63:0] m_res_rx_time,
  output logic [31:0] match_count,
  output logic [15:0] overflow_count
);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             match_q, match_d;
  logic [31:0]      seq_q, seq_d;
  logic [63:0]      tx_q, tx_d;
  logic [63:0]      rxts_q, rxts_d;

  logic             res_valid_q;
  logic [31:0]      res_seq_q;
  logic [63:0]      res_tx_q, res_rx_q;
  logic [31:0]      match_cnt_q;
  logic [15:0]      ovf_cnt_q;

  logic             beat_c, last_c, commit_c, hs_c, care_c;
  logic [7:0]       exp_byte_c;

  // A tkeep=0 beat carries no byte but its tlast still closes the frame.
  assign beat_c = s_axis_tvalid & s_axis_tkeep;
  assign last_c = s_axis_tvalid & s_axis_tlast;
  assign hs_c   = res_valid_q & m_res_ready;

  eth_ping_rx_hdr_cmp #(
    .main_mac   (main_mac),
    .identifier (identifier),
    .ethertype  (ethertype)
  ) u_hdr_cmp (
    .offset_i     (off_q),
    .exp_byte_c_o (exp_byte_c),
    .care_c_o     (care_c)
  );

  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) state_q <= ST_SYNC;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (!s_axis_tvalid || s_axis_tlast) state_d = ST_IDLE;
      ST_IDLE: begin
        if (last_c)      state_d = ST_IDLE;
        else if (beat_c) state_d = (enable && time_running) ? ST_HDR : ST_TAIL;
      end
      ST_HDR: begin
        if (last_c)                          state_d = ST_IDLE;
        else if (beat_c && off_q == OFF_END) state_d = ST_TAIL;
      end
      ST_TAIL: if (last_c) state_d = ST_IDLE;
      default: state_d = ST_SYNC;
    endcase
  end

  // Header datapath: compare, capture and decide commit on counted beats.
  always_comb begin
    off_d    = off_q;
    match_d  = match_q;
    seq_d    = seq_q;
    tx_d     = tx_q;
    rxts_d   = rxts_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_HDR: begin
        if (beat_c) begin
          if (state_q == ST_IDLE) rxts_d = current_time;
          if (care_c && (s_axis_tdata != exp_byte_c)) match_d = 1'b0;
          if (off_q >= OFF_SEQ && off_q < OFF_TX) seq_d = {seq_q[23:0], s_axis_tdata};
          if (off_q >= OFF_TX) tx_d = {tx_q[55:0], s_axis_tdata};
          off_d    = off_q + OFF_W'(1);
          commit_c = (state_q == ST_HDR) && (off_q == OFF_END) && match_q;
        end
      end
      ST_TAIL: if (beat_c && off_q != '1) off_d = off_q + OFF_W'(1);
      default: ;
    endcase
    if (state_d == ST_IDLE) begin
      off_d   = '0;
      match_d = 1'b1;
    end
  end

  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      off_q   <= '0;
      match_q <= 1'b1;
      seq_q   <= '0;
      tx_q    <= '0;
      rxts_q  <= '0;
    end else begin
      off_q   <= off_d;
      match_q <= match_d;
      seq_q   <= seq_d;
      tx_q    <= tx_d;
      rxts_q  <= rxts_d;
    end
  end

  // Single-entry result slot; a commit while the slot is held is dropped.
  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      res_valid_q <= 1'b0;
      res_seq_q   <= '0;
      res_tx_q    <= '0;
      res_rx_q    <= '0;
      match_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else if (commit_c && (!res_valid_q || m_res_ready)) begin
      res_valid_q <= 1'b1;
      res_seq_q   <= seq_q;
      res_tx_q    <= tx_d;
      res_rx_q    <= rxts_q;
      match_cnt_q <= match_cnt_q + 32'd1;
    end else if (commit_c) begin
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end else if (hs_c) begin
      res_valid_q <= 1'b0;
    end
  end

  assign m_res_valid    = res_valid_q;
  assign m_res_seq      = res_seq_q;
  assign m_res_tx_time  = res_tx_q;
  assign m_res_rx_time  = res_rx_q;
  assign match_count    = match_cnt_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: doc/eth_ping_rx.md
ETH_PING_RX -- requirements
Module: eth_ping_rx

Interface
REQ-001 SHALL have parameter main_mac, default 48'h7A_65_64_6E_74_6D, meaning the destination MAC accepted.
REQ-002 SHALL have parameter identifier, default 32'h50696E47, meaning the payload tag that marks a ping frame.
REQ-003 SHALL have parameter ethertype, default 16'h88B5, meaning the EtherType accepted.
REQ-004 SHALL have one clock and an asynchronous active-low reset: s_axis_clk (input, 1, clock) and s_axis_resetn (input, 1, reset).
REQ-005 SHALL have port enable, input, 1 bit: parsing enabled.
REQ-006 SHALL have ports s_axis_tdata (input, 8), s_axis_tkeep (input, 1), s_axis_tlast (input, 1) and s_axis_tvalid (input, 1): the TEMAC RX stream, which has no tready.
REQ-007 SHALL have ports current_time (input, 64) and time_running (input, 1): the timer.
REQ-008 SHALL have ports m_res_valid (output, 1) and m_res_ready (input, 1): the result handshake.
REQ-009 SHALL have ports m_res_seq (output, 32), m_res_tx_time (output, 64) and m_res_rx_time (output, 64): the result fields.
REQ-010 SHALL have ports match_count (output, 32) and overflow_count (output, 16): the statistics counters.

Function
REQ-011 SHALL count a beat only when s_axis_tvalid=1 and s_axis_tkeep=1; a tvalid beat with tkeep=0 SHALL NOT advance the byte offset, but its tlast SHALL still end the frame.
REQ-012 SHALL latch current_time on a frame's first counted beat (offset 0) as the rx timestamp.
REQ-013 SHALL interpret the frame layout big-endian: offsets 0-5 destination MAC, 6-11 source MAC (ignored), 12-13 EtherType, 14-17 identifier, 18-21 seq, 22-29 tx_time.
REQ-014 SHALL implement FSM states SYNC, IDLE, HDR, TAIL, each defined by the following requirements.
REQ-015 SYNC (the reset state) SHALL go to IDLE after any cycle with tvalid=0 or after a tlast beat, so that a tail seen after reset is never parsed.
REQ-016 IDLE SHALL go to HDR on a counted beat when enable=1 and time_running=1; otherwise it SHALL go to TAIL, unless that beat has tlast, in which case it stays in IDLE.
REQ-017 HDR SHALL compare each byte at offsets 0-17 against the parameters and clear a sticky match flag on the first mismatch.
REQ-018 HDR SHALL capture seq and tx_time from offsets 18-29.
REQ-019 HDR SHALL finish at offset 29: if the match flag is set it SHALL commit the result (REQ-022); then it SHALL go to TAIL, or to IDLE if that beat has tlast.
REQ-020 A tlast before offset 29 (runt frame) SHALL discard the frame with no result, no count change, and go to IDLE.
REQ-021 TAIL SHALL ignore bytes until tlast and then go to IDLE.
REQ-022 Commit with m_res_valid=0 SHALL register seq/tx_time/rx_time, assert m_res_valid on the next cycle and increment match_count.
REQ-023 Commit with m_res_valid=1 and no same-cycle handshake SHALL drop the new result, keep the old one and increment overflow_count.
REQ-024 On a commit in the same cycle as a handshake (m_res_valid and m_res_ready both 1), the new result SHALL be accepted and m_res_valid SHALL stay 1.
REQ-025 m_res_valid SHALL clear the cycle after valid&&ready when there is no commit.
REQ-026 The m_res_* fields SHALL stay stable while valid=1 and ready=0.
REQ-027 Latency SHALL be fixed: m_res_valid rises one cycle after the offset-29 beat.
REQ-028 match_count SHALL wrap modulo 2^32; overflow_count SHALL saturate at 16'hFFFF.
REQ-029 enable or time_running falling mid-frame SHALL NOT abort the frame already in progress.
REQ-030 The byte offset counter SHALL be 5 bits wide and SHALL saturate in TAIL.

Reset
REQ-031 Asserting s_axis_resetn low SHALL asynchronously set: state SYNC, m_res_valid 0, m_res_seq/tx_time/rx_time 0, match_count 0, overflow_count 0, offset 0, match flag 1.
REQ-032 Reset mid-frame or with a pending result SHALL discard both; after reset deassertion the first frame is parsed only after SYNC exit.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the offset constants (OFF_ETYPE=12, OFF_ID=14, OFF_SEQ=18, OFF_TX=22, OFF_END=29) and the default ethertype.
REQ-034 The block SHALL have one sub-module, eth_ping_rx_hdr_cmp: a combinational expected-byte lookup by offset from the parameters.

Verification
REQ-035 Matching 64-byte frame with seq=0x00000005, tx_time=0x1122334455667788, current_time=1000 at byte 0 -> one result {5, 0x1122334455667788, 1000}, valid at offset-29 beat +1 cycle, match_count=1.
REQ-036 Same frame with destination-MAC byte 3 altered, then a frame with identifier 0x50696E48 -> no result, match_count=0.
REQ-037 Two matching frames with m_res_ready held 0 -> first result retained and unchanged, overflow_count=1; ready=1 on the second commit cycle -> second result accepted, overflow_count=0.
REQ-038 20-byte runt with tlast at offset 19 followed by a valid frame -> only the second frame is reported.
REQ-039 Reset asserted at offset 10 and released at offset 15 of a matching frame -> no result; the next frame is reported; time_running=0 at frame start -> no result.
